// File: rtl/mem_port_pkg.sv
// mem_port shared types: FSM state encoding and bus widths.
// Address/data width is shared with the AGU.
package mem_port_pkg;

  localparam int DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_port.sv
// Memory bus master: one 4-phase req/ack access per command,
// with read-data capture and a bounded wait for acknowledge.
module mem_port
  import mem_port_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] adr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  input  logic          wr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic [DW-1:0] bus_adr,
  output logic [DW-1:0] bus_dout,
  output logic          bus_we,
  output logic          bus_req,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_din
);

  state_t        state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      bus_adr  <= '0;
      bus_dout <= '0;
      bus_we   <= 1'b0;
      bus_req  <= 1'b0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (rd || wr) begin
            bus_adr <= adr;
            if (wr) bus_dout <= wdata;
            bus_we  <= wr;
            bus_req <= 1'b1;
            busy    <= 1'b1;
            cnt     <= '0;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            done    <= 1'b1;
            if (!bus_we) rdata <= bus_din;
            state   <= ST_REL;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            bus_req <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
            state   <= ST_REL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_REL: begin
          // drain any ack still high so it can't finish the next access
          if (!bus_ack) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
